// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state, instruction width and PC step for the fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO, async active-low reset, synchronous clear
// Ports: clk/rst_n, push+wdata, pop, clr (drops all entries, wins over push/pop),
// rdata (head entry), count (entries held). Push when full and pop when empty are ignored.
module ifu_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & (cnt_q != FULL) & ~clr;
    do_pop = pop & (cnt_q != '0) & ~clr;
    wp_d = clr ? '0 : wp_q + AW'(do_push);
    rp_d = clr ? '0 : rp_q + AW'(do_pop);
    cnt_d = clr ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wp_q] <= wdata;
    end
  end
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit, sole writer of the PC register
// Ports: i_clk/i_resetn; i_pc in, o_pc_we/o_pc_next out (PC register);
// o_imem_req/o_imem_addr/i_imem_gnt/i_imem_rvalid/i_imem_rdata (in-order memory);
// o_id_valid/o_id_instr/o_id_pc/i_id_ready (decode); i_redirect/i_redirect_pc (execute).
// Optional IFU_PERF_EN adds o_fetch_cnt, the count of instructions taken by decode.
module ifu_fetch import ifu_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [31:0] i_pc,
  output logic        o_pc_we,
  output logic [31:0] o_pc_next,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_id_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] o_fetch_cnt
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(BUF_DEPTH);
  state_t state_q, state_d;
  logic [CW-1:0] outst, bufc, outst_nx, drop_q, drop_d;
  logic redir, req, grant, rv_ok, dropping;
  logic [XLEN-1:0] pcq_head;
  logic [2*XLEN-1:0] buf_head;
  // Everything is gated by reset so the PC register sees no write while held in reset.
  // Credits use registered counts only: a pop this cycle frees its slot next cycle.
  always_comb begin
    redir = i_redirect & i_resetn;
    rv_ok = i_imem_rvalid & (outst != '0);
    req = state_q == RUN && ({1'b0, outst} + {1'b0, bufc}) < LIMIT && !redir;
    grant = req & i_imem_gnt;
    dropping = state_q == FLUSH && drop_q != '0;
    outst_nx = outst + CW'(grant) - CW'(rv_ok);
    o_pc_we = i_resetn & (state_q == BOOT | redir | grant);
    o_pc_next = redir ? i_redirect_pc : grant ? i_pc + PC_INC : RESET_PC;
    drop_d = redir ? outst_nx : (dropping && rv_ok) ? drop_q - CW'(1) : drop_q;
    state_d = redir ? (outst_nx != '0 ? FLUSH : RUN) :
              state_q == BOOT ? RUN :
              (state_q == FLUSH && drop_d == '0) ? RUN : state_q;
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= BOOT;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
    end
  end
  ifu_fifo #(.W(XLEN), .DEPTH(BUF_DEPTH)) u_pcq (
    .clk(i_clk), .rst_n(i_resetn), .push(grant), .pop(rv_ok), .clr(1'b0),
    .wdata(i_pc), .rdata(pcq_head), .count(outst)
  );
  ifu_fifo #(.W(2*XLEN), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(i_clk), .rst_n(i_resetn), .push(rv_ok & ~dropping & ~redir),
    .pop(o_id_valid & i_id_ready), .clr(redir),
    .wdata({i_imem_rdata, pcq_head}), .rdata(buf_head), .count(bufc)
  );
  assign o_imem_req = req;
  assign o_imem_addr = i_pc;
  assign o_id_valid = bufc != '0;
  assign o_id_instr = buf_head[2*XLEN-1:XLEN];
  assign o_id_pc = buf_head[XLEN-1:0];
`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  always_comb fetch_cnt_d = fetch_cnt_q + 32'(o_id_valid & i_id_ready);
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) fetch_cnt_q <= '0;
    else fetch_cnt_q <= fetch_cnt_d;
  end
  assign o_fetch_cnt = fetch_cnt_q;
`endif
endmodule
